alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter FIXED_PRIO, default 0, 0 = round-robin between requesters, 1 = requester 0 always wins ties.
REQ-002 Parameter R1_FLAGS, default 0, 1 = requester 1 may update ALU flags register, 0 = requester 1 never updates flags.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 r0_valid, r1_valid  in  1  operation request from requester 0 / 1.
REQ-006 r0_ready, r1_ready  out  1  request accepted this cycle (valid & ready).
REQ-007 r0_mode, r1_mode  in  4  ALU opcode (0000 ADD ... 1001 A pass, others B pass).
REQ-008 r0_a, r0_b, r1_a, r1_b  in  16  operands.
REQ-009 r0_carry, r1_carry  in  1  carry-in for ADD/SUB.
REQ-010 r0_flags_we, r1_flags_we  in  1  request that this op update ALU flags.
REQ-011 r0_resp_valid, r1_resp_valid  out  1  one-cycle pulse, result valid.
REQ-012 r0_result, r1_result  out  16  registered result, held until next response to same requester.
REQ-013 alu_a, alu_b  out  16  operands to shared ALU.
REQ-014 alu_mode  out  4  opcode to shared ALU.
REQ-015 alu_carry  out  1  carry-in to shared ALU.
REQ-016 alu_flags_ie  out  1  flags-register load enable to shared ALU.
REQ-017 alu_out  in  16  combinational ALU result.

Function
REQ-018 FSM states IDLE and EXEC; reset state IDLE.
REQ-019 Readys are combinational, asserted only in IDLE, at most one per cycle, only to a requester with valid high.
REQ-020 IDLE, one valid: that requester gets ready; on the edge, operands/mode/carry/flags_we and owner ID latch, FSM -> EXEC.
REQ-021 IDLE, both valid, FIXED_PRIO=0: grant goes to requester not granted last; last-grant register resets to 1 so r0 wins the first tie.
REQ-022 IDLE, both valid, FIXED_PRIO=1: r0 granted; r1 waits indefinitely.
REQ-023 Last-grant register updates only on an accepted request.
REQ-024 EXEC lasts exactly one cycle: alu_a/alu_b/alu_mode/alu_carry driven from latched values; FSM -> IDLE on next edge unconditionally.
REQ-025 alu_flags_ie = 1 only in EXEC and only if latched flags_we=1 and (owner=0 or R1_FLAGS=1); 0 in all other cycles.
REQ-026 End of EXEC edge: alu_out captured into owner's result register; owner's resp_valid high for the following cycle only.
REQ-027 Latency: accept edge N, EXEC cycle N+1, resp_valid and result visible cycle N+2; throughput one op per 2 cycles.
REQ-028 A new request may be accepted in the same cycle resp_valid is high (back-to-back: accepts every second cycle).
REQ-029 In IDLE, alu_a, alu_b = 0, alu_mode = 4'b1010, alu_carry = 0.
REQ-030 Valid dropped before ready: no operation, no state change.
REQ-031 Non-owner result register and resp_valid unaffected by an operation.
REQ-032 Opcode is passed through unmodified; the block imposes no arithmetic or width rules on data.

Reset
REQ-033 rst_n low asynchronously forces: FSM IDLE, last-grant = 1, both resp_valid = 0, both results = 0, readys = 0, ALU outputs per REQ-029, alu_flags_ie = 0.
REQ-034 Reset during EXEC aborts the op: no resp_valid, no flags update; requester must reissue.
REQ-035 After rst_n deasserts, a request may be accepted on the first rising edge.

Verification
REQ-036 r0 ADD a=0x0003 b=0x0004 carry=1 flags_we=1 -> r0_ready in cycle 0, alu_flags_ie=1 in cycle 1, r0_resp_valid cycle 2 with r0_result=0x0008.
REQ-037 r0 and r1 valid continuously, FIXED_PRIO=0 -> grants alternate r0,r1,r0,r1 every 2 cycles; never both readys high.
REQ-038 Same as REQ-037 with FIXED_PRIO=1 -> only r0 granted; r1_ready stays 0.
REQ-039 r1 SUB a=0x0000 b=0x0001 flags_we=1, R1_FLAGS=0 -> r1_result=0xFFFF, alu_flags_ie=0 throughout; r0_result unchanged.
REQ-040 rst_n pulled low during EXEC of r0 XOR -> no r0_resp_valid, all outputs at reset values, next request after release completes normally.
REQ-041 r0 pulses valid one cycle while FSM in EXEC, then drops -> no ready, no response, FSM returns IDLE.

Source files
------------

// File: rtl/alu_arb_if.sv
// Bundle of the two requester channels and the shared-ALU channel of alu_arb.
// Handshake: a requester holds rN_valid and its operands stable until it sees
// rN_ready; the transfer happens on the rising edge where valid & ready are
// both high. rN_resp_valid is a one-cycle pulse and is not back-pressured.
interface alu_arb_if;
    logic        r0_valid;
    logic        r1_valid;
    logic        r0_ready;
    logic        r1_ready;
    logic [3:0]  r0_mode;
    logic [3:0]  r1_mode;
    logic [15:0] r0_a;
    logic [15:0] r0_b;
    logic [15:0] r1_a;
    logic [15:0] r1_b;
    logic        r0_carry;
    logic        r1_carry;
    logic        r0_flags_we;
    logic        r1_flags_we;
    logic        r0_resp_valid;
    logic        r1_resp_valid;
    logic [15:0] r0_result;
    logic [15:0] r1_result;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_mode;
    logic        alu_carry;
    logic        alu_flags_ie;
    logic [15:0] alu_out;

    // Arbiter side
    modport slave (
        input  r0_valid, r1_valid, r0_mode, r1_mode, r0_a, r0_b, r1_a, r1_b,
               r0_carry, r1_carry, r0_flags_we, r1_flags_we, alu_out,
        output r0_ready, r1_ready, r0_resp_valid, r1_resp_valid,
               r0_result, r1_result, alu_a, alu_b, alu_mode, alu_carry,
               alu_flags_ie
    );

    // Requesters plus the shared ALU
    modport master (
        output r0_valid, r1_valid, r0_mode, r1_mode, r0_a, r0_b, r1_a, r1_b,
               r0_carry, r1_carry, r0_flags_we, r1_flags_we, alu_out,
        input  r0_ready, r1_ready, r0_resp_valid, r1_resp_valid,
               r0_result, r1_result, alu_a, alu_b, alu_mode, alu_carry,
               alu_flags_ie
    );
endinterface

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of a shared combinational ALU.
// IDLE grants at most one requester and latches its operation; EXEC drives
// the ALU for one cycle and captures alu_out into the owner's result register.
// dbg_exec exposes the FSM state (0 = IDLE, 1 = EXEC).
module alu_arb #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter bit R1_FLAGS   = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_arb_if.slave bus,
    output logic     dbg_exec
);
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    // Opcode presented to the ALU while nothing is executing (B pass of 0)
    localparam logic [3:0] IDLE_MODE = 4'b1010;

    state_t      state_q, state_d;
    logic        last_q, last_d;      // 1 = r1 was granted most recently
    logic        owner_q, owner_d;    // requester of the latched op
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  mode_q, mode_d;
    logic        carry_q, carry_d;
    logic        fwe_q, fwe_d;
    logic [15:0] res0_q, res0_d;
    logic [15:0] res1_q, res1_d;
    logic        rv0_q, rv0_d;
    logic        rv1_q, rv1_d;

    logic        pick_r0;
    logic        grant0;
    logic        grant1;

    // Arbitration: grant only in IDLE, out of reset, to a valid requester
    always_comb begin
        pick_r0 = FIXED_PRIO ? 1'b1 : last_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (bus.r0_valid && bus.r1_valid) begin
                grant0 = pick_r0;
                grant1 = !pick_r0;
            end else begin
                grant0 = bus.r0_valid;
                grant1 = bus.r1_valid;
            end
        end
    end

    // Next-state: latch on accept, execute and respond on the following edge
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        fwe_d   = fwe_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d = EXEC;
                    last_d  = grant1;
                    owner_d = grant1;
                    a_d     = grant1 ? bus.r1_a        : bus.r0_a;
                    b_d     = grant1 ? bus.r1_b        : bus.r0_b;
                    mode_d  = grant1 ? bus.r1_mode     : bus.r0_mode;
                    carry_d = grant1 ? bus.r1_carry    : bus.r0_carry;
                    fwe_d   = grant1 ? bus.r1_flags_we : bus.r0_flags_we;
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (owner_q) begin
                    res1_d = bus.alu_out;
                    rv1_d  = 1'b1;
                end else begin
                    res0_d = bus.alu_out;
                    rv0_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset also aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            mode_q  <= 4'h0;
            carry_q <= 1'b0;
            fwe_q   <= 1'b0;
            res0_q  <= 16'h0000;
            res1_q  <= 16'h0000;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            fwe_q   <= fwe_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    // Output drive: ALU sees the latched op only during EXEC
    always_comb begin
        bus.r0_ready      = grant0;
        bus.r1_ready      = grant1;
        bus.r0_resp_valid = rv0_q;
        bus.r1_resp_valid = rv1_q;
        bus.r0_result     = res0_q;
        bus.r1_result     = res1_q;
        dbg_exec          = (state_q == EXEC);
        if (state_q == EXEC) begin
            bus.alu_a     = a_q;
            bus.alu_b     = b_q;
            bus.alu_mode  = mode_q;
            bus.alu_carry = carry_q;
        end else begin
            bus.alu_a     = 16'h0000;
            bus.alu_b     = 16'h0000;
            bus.alu_mode  = IDLE_MODE;
            bus.alu_carry = 1'b0;
        end
        bus.alu_flags_ie = (state_q == EXEC) && fwe_q && (!owner_q || R1_FLAGS);
    end
endmodule
